wb_regfile_sb: RTL and testbench
================================

Name: wb_regfile_sb

Overview:
- Write-back stage plus register file. Consumes the write-back bundle (write enable, destination, data) that the EX-to-WB pipeline register presents one cycle after EX, and commits it to the register file.
- Provides two bypassed read ports for the decode stage.
- Keeps a per-register in-flight-write scoreboard so decode can detect RAW hazards and stall.

Parameters:
- NUM_REGS, 16, number of architectural registers; equals 2**width of t_RFadrs.
- MAX_INFLIGHT, 3, maximum outstanding issued writes per register; sets counter width to 2 bits.
- REG0_ZERO, 1, if 1 then R0 reads 0, ignores writes and is never marked busy.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write-back enable from the EX-to-WB register output.
- wr_dst  in  t_RFadrs  write-back destination register.
- wr_data  in  t_data  write-back data.
- rd_adrs_a  in  t_RFadrs  decode source A address.
- rd_adrs_b  in  t_RFadrs  decode source B address.
- rd_data_a  out  t_data  source A data, combinational, bypassed.
- rd_data_b  out  t_data  source B data, combinational, bypassed.
- issue_en  in  1  decode issues an instruction that will write issue_dst.
- issue_dst  in  t_RFadrs  destination of the issued instruction.
- src_a_busy  out  1  source A has an outstanding write not yet visible.
- src_b_busy  out  1  source B has an outstanding write not yet visible.
- issue_ok  out  1  scoreboard can accept issue_dst this cycle.
- sb_underflow  out  1  sticky error flag: write-back to a register with zero in-flight count.

Behaviour:
- Reset (rst_n low, asynchronous): all registers := 0, all counters := 0, sb_underflow := 0. Outputs settle combinationally from the reset state: rd_data_* = 0, busy = 0, issue_ok = 1.
- Write:
  - On the rising clock edge with wr_en=1, rf[wr_dst] := wr_data.
  - With REG0_ZERO=1 and wr_dst=0, the write is dropped.
  - Write latency 1 cycle; the value is visible through the bypass in the same cycle.
- Read:
  - rd_data_x = wr_data if wr_en && wr_dst==rd_adrs_x && !(REG0_ZERO && rd_adrs_x==0).
  - Otherwise rd_data_x = rf[rd_adrs_x], or 0 for R0 when REG0_ZERO=1.
  - Both ports are independent; the same address on both ports is legal.
- Scoreboard counter cnt[r], per register:
  - inc = issue_en && issue_ok && !(REG0_ZERO && issue_dst==0).
  - dec = wr_en && cnt[wr_dst]!=0 && !(REG0_ZERO && wr_dst==0).
  - Same register with inc and dec in the same cycle: cnt unchanged.
  - Otherwise cnt[issue_dst]+=inc and cnt[wr_dst]-=dec.
- issue_ok = cnt[issue_dst] < MAX_INFLIGHT. It is evaluated before this cycle's dec; the conservative choice is intentional. R0 is always ok.
- src_x_busy = (cnt[rd_adrs_x] - (wr_en && wr_dst==rd_adrs_x ? 1 : 0)) != 0. A write retiring this cycle is covered by the bypass. R0 is never busy.
- Underflow: wr_en with cnt[wr_dst]==0 on a non-R0 register.
  - The data write still occurs.
  - The counter stays 0.
  - sb_underflow is set on the next edge and held until reset.
- Issue while issue_ok=0: ignored by the scoreboard. Decode must stall; the block never buffers issues.
- Reset mid-operation: all in-flight counts are discarded immediately. Write-backs already in the pipeline after reset release count as underflow.
- No internal state machine beyond the counters. All state updates on the rising clock edge only.

Decomposition:
- Shared package, extended with the following. t_data and t_RFadrs already live there.
  - t_sbcnt: 2-bit counter type.
  - NUM_REGS.
  - MAX_INFLIGHT.
- Sub-module: sb_counter. Holds one register's saturating up/down counter, with inc, dec and a busy/full output. The top instantiates NUM_REGS of them in a generate loop.
- The register array and bypass muxes stay in the top.

Test Plan:
- Reset, then read R5/R6 -> rd_data 0, busy 0, issue_ok 1. Assert rst_n mid-traffic -> all counts 0 immediately.
- issue R3; two cycles later wr_en=1, wr_dst=3, wr_data=0xA5 while rd_adrs_a=3 -> src_a_busy 0, rd_data_a=0xA5 that cycle and 0xA5 from rf next cycle.
- issue R4 three times, no write-back; fourth issue R4 -> issue_ok 0, cnt stays 3. One write-back to R4 -> issue_ok 1 next cycle, src busy stays 1 until the third retire.
- Same cycle: issue R7 and write-back R7 with cnt=1 -> cnt stays 1, src busy on R7 = 1.
- wr_en=1, wr_dst=0, wr_data=0xFF with REG0_ZERO=1 -> rd R0 = 0, no underflow. Issue R0 -> no counter change.
- wr_en to R9 with cnt 0, data 0x3C -> rf[9]=0x3C, sb_underflow=1 next cycle, held until rst_n low.

Source files
------------

// File: rtl/wb_regfile_sb_pkg.sv
// Shared types and sizing for the write-back stage / register file /
// scoreboard slice.
//   t_data   : architectural data word
//   t_RFadrs : register-file address (NUM_REGS = 2**width)
//   t_sbcnt  : per-register in-flight write counter
package wb_regfile_sb_pkg;

  localparam int DATA_W       = 32;
  localparam int RF_ADRS_W    = 4;
  localparam int NUM_REGS     = 2 ** RF_ADRS_W;
  localparam int MAX_INFLIGHT = 3;
  localparam int SB_CNT_W     = 2;

  typedef logic [DATA_W-1:0]    t_data;
  typedef logic [RF_ADRS_W-1:0] t_RFadrs;
  typedef logic [SB_CNT_W-1:0]  t_sbcnt;

  // Counter value at which a register refuses further issues.
  localparam t_sbcnt SB_CNT_MAX = t_sbcnt'(MAX_INFLIGHT);

endpackage

// File: rtl/wb_regfile_sb_if.sv
// Bundle of every non-clock signal between the pipeline/decode side and the
// write-back + register-file block.
//
// Handshake semantics: there is no ready/valid pair here. wr_en qualifies
// wr_dst/wr_data for one cycle and is always accepted. issue_en qualifies
// issue_dst; the issue is accepted on the rising edge only when issue_ok is
// high in that same cycle, otherwise decode must hold and retry.
//
//   master : decode / EX-to-WB register side (drives requests)
//   slave  : wb_regfile_sb (drives read data and scoreboard status)
interface wb_regfile_sb_if;
  import wb_regfile_sb_pkg::*;

  logic    wr_en;
  t_RFadrs wr_dst;
  t_data   wr_data;
  t_RFadrs rd_adrs_a;
  t_RFadrs rd_adrs_b;
  t_data   rd_data_a;
  t_data   rd_data_b;
  logic    issue_en;
  t_RFadrs issue_dst;
  logic    src_a_busy;
  logic    src_b_busy;
  logic    issue_ok;
  logic    sb_underflow;

  modport master (
    output wr_en, wr_dst, wr_data, rd_adrs_a, rd_adrs_b, issue_en, issue_dst,
    input  rd_data_a, rd_data_b, src_a_busy, src_b_busy, issue_ok, sb_underflow
  );

  modport slave (
    input  wr_en, wr_dst, wr_data, rd_adrs_a, rd_adrs_b, issue_en, issue_dst,
    output rd_data_a, rd_data_b, src_a_busy, src_b_busy, issue_ok, sb_underflow
  );

endinterface

// File: rtl/wb_regfile_sb_sb_counter.sv
// One register's in-flight write counter.
//   clock, rst_n : clock and asynchronous active-low reset
//   inc          : an issue targeting this register was accepted
//   dec          : a write-back retired one outstanding write
//   cnt          : current count
//   busy         : count is non-zero
//   full         : count has reached SB_CNT_MAX
// Saturates at both ends; simultaneous inc and dec cancel.
module sb_counter
  import wb_regfile_sb_pkg::*;
(
  input  logic   clock,
  input  logic   rst_n,
  input  logic   inc,
  input  logic   dec,
  output t_sbcnt cnt,
  output logic   busy,
  output logic   full
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != SB_CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign full = (cnt >= SB_CNT_MAX);

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back stage plus register file with a per-register RAW scoreboard.
//   clock, rst_n : clock and asynchronous active-low reset
//   bus (slave)  : write-back bundle, two bypassed read ports, issue request
//                  and scoreboard status (src busy, issue_ok, sticky
//                  sb_underflow)
// REG0_ZERO=1 makes R0 read as zero, drop writes and never count as busy.
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
#(
  parameter bit REG0_ZERO = 1'b1
) (
  input  logic           clock,
  input  logic           rst_n,
  wb_regfile_sb_if.slave bus
);

  t_data                rf   [NUM_REGS];
  t_sbcnt               cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  full;
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  dec_vec;

  logic wr_to_r0;
  logic issue_to_r0;
  logic zero_a;
  logic zero_b;
  logic hit_a;
  logic hit_b;
  logic issue_ok;
  logic underflow_q;

  assign wr_to_r0    = REG0_ZERO && (bus.wr_dst == '0);
  assign issue_to_r0 = REG0_ZERO && (bus.issue_dst == '0);
  assign zero_a      = REG0_ZERO && (bus.rd_adrs_a == '0);
  assign zero_b      = REG0_ZERO && (bus.rd_adrs_b == '0);
  assign hit_a       = bus.wr_en && (bus.wr_dst == bus.rd_adrs_a);
  assign hit_b       = bus.wr_en && (bus.wr_dst == bus.rd_adrs_b);

  // Register array; writes to a hard-wired R0 are dropped.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.wr_en && !wr_to_r0) begin
      rf[bus.wr_dst] <= bus.wr_data;
    end
  end

  // Read ports: a write retiring this cycle is forwarded straight through.
  assign bus.rd_data_a = zero_a ? '0 : (hit_a ? bus.wr_data : rf[bus.rd_adrs_a]);
  assign bus.rd_data_b = zero_b ? '0 : (hit_b ? bus.wr_data : rf[bus.rd_adrs_b]);

  // issue_ok looks at the count before this cycle's retire, so a full
  // register stays blocked for one extra cycle. That is deliberate: it keeps
  // issue_ok independent of the write-back path timing.
  assign issue_ok     = issue_to_r0 || !full[bus.issue_dst];
  assign bus.issue_ok = issue_ok;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    localparam t_RFadrs REG_ID = t_RFadrs'(r);

    assign inc_vec[r] = bus.issue_en && issue_ok && !issue_to_r0 &&
                        (bus.issue_dst == REG_ID);
    assign dec_vec[r] = bus.wr_en && !wr_to_r0 && busy[r] &&
                        (bus.wr_dst == REG_ID);

    sb_counter u_cnt (
      .clock (clock),
      .rst_n (rst_n),
      .inc   (inc_vec[r]),
      .dec   (dec_vec[r]),
      .cnt   (cnt[r]),
      .busy  (busy[r]),
      .full  (full[r])
    );
  end

  // A source is busy unless its only outstanding write is the one being
  // forwarded this cycle. Written as a compare rather than cnt-1 so that a
  // stray write-back to an idle register cannot wrap and read as busy.
  assign bus.src_a_busy = !zero_a && busy[bus.rd_adrs_a] &&
                          !(hit_a && cnt[bus.rd_adrs_a] == t_sbcnt'(1));
  assign bus.src_b_busy = !zero_b && busy[bus.rd_adrs_b] &&
                          !(hit_b && cnt[bus.rd_adrs_b] == t_sbcnt'(1));

  // Sticky: a write-back arrived for a register with nothing in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (bus.wr_en && !wr_to_r0 && !busy[bus.wr_dst]) begin
      underflow_q <= 1'b1;
    end
  end

  assign bus.sb_underflow = underflow_q;

endmodule

// File: tb/tb_wb_regfile_sb.sv
module tb_wb_regfile_sb;
  import wb_regfile_sb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  wb_regfile_sb_if bus();

  wb_regfile_sb #(.REG0_ZERO(1'b1)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_rf  [16];
  int          m_cnt [16];
  bit          m_uf;
  logic [31:0] exp_q [$];
  int          inflight_q [$];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rf[i]  = '0;
      m_cnt[i] = 0;
    end
    m_uf = 1'b0;
    inflight_q.delete();
  endfunction

  // Applied at each rising edge using the inputs held during the cycle.
  function automatic void model_update();
    int  inc_r = -1;
    int  dec_r = -1;
    bit  uf    = 1'b0;
    if (bus.issue_en && bus.issue_dst != 0 && m_cnt[bus.issue_dst] < MAX_INFLIGHT)
      inc_r = int'(bus.issue_dst);
    if (bus.wr_en && bus.wr_dst != 0) begin
      if (m_cnt[bus.wr_dst] > 0) dec_r = int'(bus.wr_dst);
      else uf = 1'b1;
      m_rf[bus.wr_dst] = bus.wr_data;
    end
    if (inc_r >= 0) m_cnt[inc_r] = m_cnt[inc_r] + 1;
    if (dec_r >= 0) m_cnt[dec_r] = m_cnt[dec_r] - 1;
    if (uf) m_uf = 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 0) return '0;
    if (bus.wr_en && bus.wr_dst == a) return bus.wr_data;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    int pending;
    if (a == 0) return 1'b0;
    pending = m_cnt[a] - ((bus.wr_en && bus.wr_dst == a) ? 1 : 0);
    return pending > 0;
  endfunction

  function automatic logic exp_ok();
    return (bus.issue_dst == 0) || (m_cnt[bus.issue_dst] < MAX_INFLIGHT);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.wr_en     = 1'b0;
    bus.wr_dst    = '0;
    bus.wr_data   = '0;
    bus.issue_en  = 1'b0;
    bus.issue_dst = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (rst_n) model_update();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    bus.rd_adrs_a = 4'd5;
    bus.rd_adrs_b = 4'd6;
    bus.issue_dst = 4'd5;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (bus.rd_data_a !== 32'h0) $display("FAIL reset_rd_a: got %h want 0", bus.rd_data_a);
    else n_pass++;
    n_checks++;
    if (bus.rd_data_b !== 32'h0) $display("FAIL reset_rd_b: got %h want 0", bus.rd_data_b);
    else n_pass++;
    n_checks++;
    if (bus.src_a_busy !== 1'b0 || bus.src_b_busy !== 1'b0)
      $display("FAIL reset_busy: got %b%b want 00", bus.src_a_busy, bus.src_b_busy);
    else n_pass++;
    n_checks++;
    if (bus.issue_ok !== 1'b1) $display("FAIL reset_issue_ok: got %b want 1", bus.issue_ok);
    else n_pass++;
    n_checks++;
    if (bus.sb_underflow !== 1'b0) $display("FAIL reset_uf: got %b want 0", bus.sb_underflow);
    else n_pass++;
    @(negedge clock);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    set_idle();
    bus.rd_adrs_a = 4'd3;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 4'd3;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.src_a_busy !== 1'b1) $display("FAIL bypass_busy_pending: got %b want 1", bus.src_a_busy);
    else n_pass++;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_dst  = 4'd3;
    bus.wr_data = 32'hA5;
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'hA5);
    #1;
    n_checks++;
    if (bus.src_a_busy !== 1'b0) $display("FAIL bypass_busy_retire: got %b want 0", bus.src_a_busy);
    else n_pass++;
    n_checks++;
    if (bus.rd_data_a !== exp_q[0]) $display("FAIL bypass_fwd: got %h want %h", bus.rd_data_a, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.rd_data_a !== exp_q[0]) $display("FAIL bypass_rf: got %h want %h", bus.rd_data_a, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    n_checks++;
    if (bus.sb_underflow !== 1'b0) $display("FAIL bypass_uf: got %b want 0", bus.sb_underflow);
    else n_pass++;
  endtask

  task automatic test_saturate();
    set_idle();
    bus.rd_adrs_a = 4'd4;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 4'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (bus.issue_ok !== exp_ok())
        $display("FAIL sat_issue_ok[%0d]: got %b want %b", k, bus.issue_ok, exp_ok());
      else n_pass++;
      tick();
    end
    bus.issue_en = 1'b0;
    #1;
    n_checks++;
    if (bus.issue_ok !== 1'b0) $display("FAIL sat_full_held: got %b want 0", bus.issue_ok);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_dst  = 4'd4;
      bus.wr_data = $urandom;
      #1;
      n_checks++;
      if (bus.issue_ok !== exp_ok())
        $display("FAIL sat_retire_ok[%0d]: got %b want %b", k, bus.issue_ok, exp_ok());
      else n_pass++;
      n_checks++;
      if (bus.src_a_busy !== exp_busy(4'd4))
        $display("FAIL sat_retire_busy[%0d]: got %b want %b", k, bus.src_a_busy, exp_busy(4'd4));
      else n_pass++;
      tick();
      bus.wr_en = 1'b0;
      #1;
      n_checks++;
      if (bus.src_a_busy !== exp_busy(4'd4) || bus.issue_ok !== exp_ok())
        $display("FAIL sat_after[%0d]: got busy %b ok %b want busy %b ok %b",
                 k, bus.src_a_busy, bus.issue_ok, exp_busy(4'd4), exp_ok());
      else n_pass++;
    end
    n_checks++;
    if (bus.rd_data_a !== m_rf[4]) $display("FAIL sat_rd: got %h want %h", bus.rd_data_a, m_rf[4]);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    set_idle();
    bus.rd_adrs_b = 4'd7;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 4'd7;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_dst  = 4'd7;
    bus.wr_data = 32'h7777_0001;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.src_b_busy !== 1'b1) $display("FAIL same_cycle_busy: got %b want 1", bus.src_b_busy);
    else n_pass++;
    n_checks++;
    if (bus.src_b_busy !== exp_busy(4'd7)) $display("FAIL same_cycle_model: got %b want %b", bus.src_b_busy, exp_busy(4'd7));
    else n_pass++;
    bus.wr_en   = 1'b1;
    bus.wr_dst  = 4'd7;
    bus.wr_data = 32'h7777_0002;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.src_b_busy !== 1'b0 || bus.rd_data_b !== 32'h7777_0002)
      $display("FAIL same_cycle_drain: got busy %b data %h want 0 77770002", bus.src_b_busy, bus.rd_data_b);
    else n_pass++;
  endtask

  task automatic test_r0();
    set_idle();
    bus.rd_adrs_a = 4'd0;
    bus.rd_adrs_b = 4'd0;
    bus.wr_en     = 1'b1;
    bus.wr_dst    = 4'd0;
    bus.wr_data   = 32'hFF;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 4'd0;
    #1;
    n_checks++;
    if (bus.rd_data_a !== 32'h0) $display("FAIL r0_no_fwd: got %h want 0", bus.rd_data_a);
    else n_pass++;
    n_checks++;
    if (bus.issue_ok !== 1'b1) $display("FAIL r0_issue_ok: got %b want 1", bus.issue_ok);
    else n_pass++;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.rd_data_b !== 32'h0 || bus.src_b_busy !== 1'b0)
      $display("FAIL r0_after: got data %h busy %b want 0 0", bus.rd_data_b, bus.src_b_busy);
    else n_pass++;
    n_checks++;
    if (bus.sb_underflow !== 1'b0) $display("FAIL r0_uf: got %b want 0", bus.sb_underflow);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit will_inc;
      set_idle();
      bus.rd_adrs_a = 4'($urandom_range(0, 15));
      bus.rd_adrs_b = ($urandom_range(0, 3) == 0) ? bus.rd_adrs_a : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_dst  = 4'd0;
        bus.wr_data = $urandom;
      end else if (inflight_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.wr_en   = 1'b1;
        bus.wr_dst  = 4'(inflight_q.pop_front());
        bus.wr_data = $urandom;
      end
      bus.issue_en  = ($urandom_range(0, 2) != 0);
      bus.issue_dst = 4'($urandom_range(0, 7));
      will_inc = bus.issue_en && bus.issue_dst != 0 && m_cnt[bus.issue_dst] < MAX_INFLIGHT;
      #1;
      n_checks++;
      if (bus.rd_data_a !== exp_rd(bus.rd_adrs_a) || bus.rd_data_b !== exp_rd(bus.rd_adrs_b)) begin
        if (errs < 10) $display("FAIL rand_rd cyc %0d: got %h %h want %h %h", cyc,
                                bus.rd_data_a, bus.rd_data_b, exp_rd(bus.rd_adrs_a), exp_rd(bus.rd_adrs_b));
        errs++;
      end else n_pass++;
      n_checks++;
      if (bus.src_a_busy !== exp_busy(bus.rd_adrs_a) || bus.src_b_busy !== exp_busy(bus.rd_adrs_b)) begin
        if (errs < 10) $display("FAIL rand_busy cyc %0d: got %b%b want %b%b", cyc,
                                bus.src_a_busy, bus.src_b_busy, exp_busy(bus.rd_adrs_a), exp_busy(bus.rd_adrs_b));
        errs++;
      end else n_pass++;
      n_checks++;
      if (bus.issue_ok !== exp_ok() || bus.sb_underflow !== m_uf) begin
        if (errs < 10) $display("FAIL rand_sb cyc %0d: got ok %b uf %b want ok %b uf %b", cyc,
                                bus.issue_ok, bus.sb_underflow, exp_ok(), m_uf);
        errs++;
      end else n_pass++;
      tick();
      if (will_inc) inflight_q.push_back(int'(bus.issue_dst));
    end
    // Drain outstanding writes so later directed tests start clean.
    while (inflight_q.size() > 0) begin
      set_idle();
      bus.wr_en   = 1'b1;
      bus.wr_dst  = 4'(inflight_q.pop_front());
      bus.wr_data = $urandom;
      tick();
    end
    set_idle();
  endtask

  task automatic test_underflow();
    set_idle();
    bus.rd_adrs_a = 4'd9;
    bus.wr_en     = 1'b1;
    bus.wr_dst    = 4'd9;
    bus.wr_data   = 32'h3C;
    #1;
    n_checks++;
    if (bus.sb_underflow !== 1'b0) $display("FAIL uf_not_yet: got %b want 0", bus.sb_underflow);
    else n_pass++;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.rd_data_a !== 32'h3C) $display("FAIL uf_data_written: got %h want 3c", bus.rd_data_a);
    else n_pass++;
    n_checks++;
    if (bus.sb_underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", bus.sb_underflow);
    else n_pass++;
    n_checks++;
    if (bus.src_a_busy !== 1'b0) $display("FAIL uf_cnt_zero: got busy %b want 0", bus.src_a_busy);
    else n_pass++;
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (bus.sb_underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", bus.sb_underflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = 4'd2;
    tick();
    bus.issue_dst = 4'd11;
    tick();
    set_idle();
    bus.rd_adrs_a = 4'd2;
    bus.rd_adrs_b = 4'd11;
    bus.issue_dst = 4'd11;
    #1;
    n_checks++;
    if (bus.src_a_busy !== 1'b1 || bus.src_b_busy !== 1'b1)
      $display("FAIL mid_pre_busy: got %b%b want 11", bus.src_a_busy, bus.src_b_busy);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.src_a_busy !== 1'b0 || bus.src_b_busy !== 1'b0)
      $display("FAIL mid_busy_cleared: got %b%b want 00", bus.src_a_busy, bus.src_b_busy);
    else n_pass++;
    n_checks++;
    if (bus.issue_ok !== 1'b1 || bus.sb_underflow !== 1'b0)
      $display("FAIL mid_flags: got ok %b uf %b want 1 0", bus.issue_ok, bus.sb_underflow);
    else n_pass++;
    n_checks++;
    if (bus.rd_data_a !== 32'h0) $display("FAIL mid_rf_cleared: got %h want 0", bus.rd_data_a);
    else n_pass++;
    @(negedge clock);
    rst_n = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_dst  = 4'd2;
    bus.wr_data = 32'hDEAD_0002;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (bus.sb_underflow !== m_uf || bus.sb_underflow !== 1'b1)
      $display("FAIL mid_stale_wb_uf: got %b want 1", bus.sb_underflow);
    else n_pass++;
    n_checks++;
    if (bus.rd_data_a !== 32'hDEAD_0002) $display("FAIL mid_stale_wb_data: got %h want dead0002", bus.rd_data_a);
    else n_pass++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    bus.rd_adrs_a = '0;
    bus.rd_adrs_b = '0;
    set_idle();
    model_reset();
    test_reset();
    test_bypass();
    test_saturate();
    test_same_cycle();
    test_r0();
    test_random();
    test_underflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
